dff_reg_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit D-flip-flop register among NREQ requesters. Each requester raises a request with its write data. The block grants exactly one requester at a time and loads that requester's data into the shared register. It then acknowledges the write and rotates priority. It sits between the sequential-storage primitives and any logic that needs a single shared state register.

---
 rtl/dff_arb_pkg.sv | 18 +
 rtl/dff_en_reg.sv | 23 ++
 rtl/dff_reg_arbiter.sv | 121 ++++++++++++
 tb/tb_dff_reg_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter:
// FSM state encoding and pointer width calculation.
package dff_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Index width for a requester population of n (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_en_reg.sv
// WIDTH-bit D register with load enable and asynchronous active-low
// clear; holds the shared state value.
module dff_en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters.
// Optional feature: define ARB_LOCK_EN to add the lock port (owner keeps
// the register for back-to-back writes while its lock bit is high).
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = ptr_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [PW-1:0]         owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic            lock_hold;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] owner_oh;
  logic [PW-1:0]   ptr_inc;
  logic            lock_now;
  logic [WIDTH-1:0] wr_data;

  // First requesting index at or after ptr; scanning offsets downwards
  // lets the smallest offset win without an early exit.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign ptr_inc  = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy     = (state != ST_IDLE);

`ifdef ARB_LOCK_EN
  assign lock_now = lock[owner];
`else
  assign lock_now = 1'b0;
`endif

  always_comb begin
    wr_data = wdata[int'(owner)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      ack       <= 1'b0;
      owner     <= '0;
      ptr       <= '0;
      lock_hold <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // The write completes even if req[owner] has already dropped.
          ack       <= 1'b1;
          gnt       <= '0;
          lock_hold <= lock_now;
          if (!lock_now) ptr <= ptr_inc;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          ack       <= 1'b0;
          lock_hold <= 1'b0;
          if (lock_hold) begin
            gnt   <= owner_oh;
            state <= ST_GRANT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  dff_en_reg #(.WIDTH(WIDTH)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_GRANT),
    .d   (wr_data),
    .q   (q)
  );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter: directed scenarios plus
// randomized traffic checked against a round-robin reference model.
module tb_dff_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int PW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       lock = '0;
`endif
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [PW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_cyc  = 0;
  int m_ptr    = 0;
  logic [WIDTH-1:0] data [NREQ];

  dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Grant is one-hot or zero, and never coincides with ack.
  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if ($countones(gnt) > 1 || (gnt != '0 && ack)) begin
        n_fail++;
        $display("FAIL gnt_exclusive: gnt=%b ack=%b required one-hot gnt and no overlap with ack", gnt, ack);
      end
    end
  end

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data[i] = v;
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  // Reference: first pending requester at or after p, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] pend, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (pend[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Waits for a grant, checks it against the model, then checks the ack
  // cycle and the return to idle; the served requester drops its req.
  task automatic serve(output int who);
    int waited;
    int exp_who;
    logic [NREQ-1:0] exp_gnt;
    waited = 0;
    while (gnt == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (gnt == '0) begin
      n_fail++;
      $display("FAIL grant_timeout: gnt=%b after %0d cycles, required a grant (req=%b)", gnt, waited, req);
      who = -1;
      return;
    end
    gnt_cyc = cyc;
    exp_who = model_pick(req, m_ptr);
    who     = exp_who;
    exp_gnt = '0;
    if (exp_who >= 0) exp_gnt[exp_who] = 1'b1;
    n_checks++;
    if (gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL grant_pick: gnt=%b required %b (req=%b ptr=%0d)", gnt, exp_gnt, req, m_ptr);
    end
    n_checks++;
    if (int'(owner) != exp_who) begin
      n_fail++;
      $display("FAIL grant_owner: owner=%0d required %0d", owner, exp_who);
    end
    if (exp_who < 0) return;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b1 || gnt !== '0 || q !== data[exp_who] || int'(owner) != exp_who) begin
      n_fail++;
      $display("FAIL write: ack=%b gnt=%b q=%h owner=%0d required ack=1 gnt=0 q=%h owner=%0d",
               ack, gnt, q, owner, data[exp_who], exp_who);
    end
    req[exp_who] = 1'b0;
    m_ptr = (exp_who + 1) % NREQ;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || q !== data[exp_who]) begin
      n_fail++;
      $display("FAIL done: ack=%b busy=%b q=%h required ack=0 busy=0 q=%h", ack, busy, q, data[exp_who]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (gnt !== '0 || ack !== 1'b0 || owner !== '0 || busy !== 1'b0 || q !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: gnt=%b ack=%b owner=%0d busy=%b q=%h required all zero", gnt, ack, owner, busy, q);
    end
    rst   = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    n_checks++;
    if (gnt !== '0 || ack !== 1'b0 || busy !== 1'b0 || q !== '0) begin
      n_fail++;
      $display("FAIL reset_release: gnt=%b ack=%b busy=%b q=%h required all zero", gnt, ack, busy, q);
    end
  endtask

  task automatic test_single();
    int who;
    set_data(1, 8'hA5);
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_latency: gnt=%b one cycle after req, required 0010", gnt);
    end
    serve(who);
    n_checks++;
    if (who != 1 || q !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_result: who=%0d q=%h required 1 and a5", who, q);
    end
  endtask

  task automatic test_simultaneous();
    int who;
    int prev_cyc;
    test_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, WIDTH'($urandom));
    req = 4'b1111;
    prev_cyc = 0;
    for (int i = 0; i < NREQ; i++) begin
      serve(who);
      n_checks++;
      if (who != i) begin
        n_fail++;
        $display("FAIL simult_order: served %0d required %0d", who, i);
      end
      if (i > 0) begin
        n_checks++;
        if (gnt_cyc - prev_cyc != 3) begin
          n_fail++;
          $display("FAIL simult_rate: %0d cycles between grants, required 3", gnt_cyc - prev_cyc);
        end
      end
      prev_cyc = gnt_cyc;
    end
  endtask

  task automatic test_wrap();
    int who;
    test_reset();
    set_data(2, 8'h3C);
    req = 4'b0100;
    serve(who);
    set_data(0, 8'h11);
    set_data(3, 8'hEE);
    req = 4'b1001;
    serve(who);
    n_checks++;
    if (who != 3) begin
      n_fail++;
      $display("FAIL wrap_first: served %0d required 3", who);
    end
    serve(who);
    n_checks++;
    if (who != 0) begin
      n_fail++;
      $display("FAIL wrap_second: served %0d required 0", who);
    end
  endtask

  task automatic test_reset_mid_op();
    int who;
    int waited;
    set_data(2, 8'h5A);
    req = 4'b0100;
    serve(who);                      // q = 5a, ptr = 3
    set_data(0, 8'h77);
    req = 4'b0001;
    waited = 0;
    while (gnt == '0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (gnt !== '0 || ack !== 1'b0 || q !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: gnt=%b ack=%b q=%h busy=%b required all zero before any edge", gnt, ack, q, busy);
    end
    req = '0;
    @(negedge clk);
    rst   = 1'b1;
    m_ptr = 0;
    set_data(1, 8'hC3);
    set_data(3, 8'h99);
    req = 4'b1010;
    serve(who);
    n_checks++;
    if (who != 1) begin
      n_fail++;
      $display("FAIL reset_ptr: served %0d required 1 (ptr cleared)", who);
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int who;
    int guard;
    logic [NREQ-1:0] mask;
    test_reset();
    for (int r = 0; r < 8; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i] && !req[i]) begin
          set_data(i, WIDTH'($urandom));
          req[i] = 1'b1;
        end
      end
      guard = 0;
      while (req != '0 && guard < 40) begin
        serve(who);
        if (who < 0) break;
        if ($urandom_range(0, 2) == 0) begin
          int j;
          j = $urandom_range(0, NREQ - 1);
          if (!req[j]) begin
            set_data(j, WIDTH'($urandom));
            req[j] = 1'b1;
          end
        end
        guard++;
      end
      req = '0;
      @(negedge clk);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int who;
    int waited;
    test_reset();
    set_data(1, 8'h42);
    req = 4'b0010;
    serve(who);                      // ptr = 2
    set_data(0, 8'h0F);
    set_data(2, 8'hB7);
    lock = 4'b0100;
    req  = 4'b0101;
    for (int w = 0; w < 3; w++) begin
      waited = 0;
      while (gnt == '0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (gnt !== 4'b0100 || (w > 0 && waited != 0)) begin
        n_fail++;
        $display("FAIL lock_grant: write %0d gnt=%b waited=%0d required 0100 with no wait", w, gnt, waited);
      end
      if (w == 2) lock = '0;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1 || q !== 8'hB7) begin
        n_fail++;
        $display("FAIL lock_write: write %0d ack=%b q=%h required ack=1 q=b7", w, ack, q);
      end
      if (w < 2) @(negedge clk);
    end
    req[2] = 1'b0;
    m_ptr  = 3;
    @(negedge clk);
    serve(who);
    n_checks++;
    if (who != 0) begin
      n_fail++;
      $display("FAIL lock_release: served %0d required 0", who);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) set_data(i, '0);
    test_reset();
    test_single();
    test_simultaneous();
    test_wrap();
    test_reset_mid_op();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
